// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if
//  Handshake/bus bundle between a payload requester and the UART TX frame
//  sequencer (uart_tx_ctrl).
//  Signals:
//    P_DATA      requester -> sequencer  parallel payload word
//    DATA_VALID  requester -> sequencer  payload valid request (level)
//    PAR_EN      requester -> sequencer  1 = insert parity bit
//    PAR_TYP     requester -> sequencer  0 = even, 1 = odd parity
//    mux_sel     sequencer -> mux        0=start 1=stop 2=ser_data 3=par_bit
//    ser_data    sequencer -> mux        current payload bit
//    par_bit     sequencer -> mux        latched parity bit
//    busy        sequencer -> requester  frame in progress
//    frame_done  sequencer -> requester  1-cycle pulse in the STOP cycle
//  Modports: master = requester side, slave = sequencer side.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [1:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  mux_sel, ser_data, par_bit, busy, frame_done
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output mux_sel, ser_data, par_bit, busy, frame_done
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//  Frame sequencer for the UART transmitter output mux. Accepts a parallel
//  word from IDLE on DATA_VALID, latches it with its parity settings, then
//  walks the mux through start, data bits (LSB first), optional parity and
//  stop, one bit per CLK.
//  Ports:
//    CLK  in  TX bit clock
//    RST  in  asynchronous reset, active-low
//    bus  uart_tx_ctrl_if.slave (payload handshake in, mux control out)
//  Parameters:
//    DATA_WIDTH  payload bits per frame (>= 2)
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  uart_tx_ctrl_if.slave      bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] MUX_START  = 2'd0;
  localparam logic [1:0] MUX_STOP   = 2'd1;
  localparam logic [1:0] MUX_DATA   = 2'd2;
  localparam logic [1:0] MUX_PARITY = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_reg;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic                   par_bit_reg;
  logic                   par_en_q_reg;
  logic [1:0]             mux_sel_reg;
  logic                   busy_reg;
  logic                   frame_done_reg;

  // Decoded outputs are loaded together with the state they belong to, so
  // they always match the registered state without a decode stage.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= S_IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      par_bit_reg    <= 1'b0;
      par_en_q_reg   <= 1'b0;
      mux_sel_reg    <= MUX_STOP;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // Level sensitive: a request still held here is taken again.
          if (bus.DATA_VALID) begin
            shift_reg      <= bus.P_DATA;
            par_en_q_reg   <= bus.PAR_EN;
            par_bit_reg    <= (^bus.P_DATA) ^ bus.PAR_TYP;
            bit_cnt_reg    <= '0;
            state_reg      <= S_START;
            mux_sel_reg    <= MUX_START;
            busy_reg       <= 1'b1;
            frame_done_reg <= 1'b0;
          end
        end

        S_START: begin
          state_reg   <= S_DATA;
          mux_sel_reg <= MUX_DATA;
        end

        S_DATA: begin
          shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
          if (bit_cnt_reg == LAST_BIT) begin
            // Counter holds at the last index instead of wrapping.
            if (par_en_q_reg) begin
              state_reg   <= S_PARITY;
              mux_sel_reg <= MUX_PARITY;
            end else begin
              state_reg      <= S_STOP;
              mux_sel_reg    <= MUX_STOP;
              frame_done_reg <= 1'b1;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          end
        end

        S_PARITY: begin
          state_reg      <= S_STOP;
          mux_sel_reg    <= MUX_STOP;
          frame_done_reg <= 1'b1;
        end

        S_STOP: begin
          // The IDLE cycle after STOP is mandatory before the next accept.
          state_reg      <= S_IDLE;
          mux_sel_reg    <= MUX_STOP;
          busy_reg       <= 1'b0;
          frame_done_reg <= 1'b0;
        end

        default: begin
          state_reg      <= S_IDLE;
          mux_sel_reg    <= MUX_STOP;
          busy_reg       <= 1'b0;
          frame_done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mux_sel    = mux_sel_reg;
  assign bus.ser_data   = shift_reg[0];
  assign bus.par_bit    = par_bit_reg;
  assign bus.busy       = busy_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  logic CLK;
  logic RST;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected per-cycle outputs of a frame, queued when the model sees an
  // accept; an empty queue means the line is idle.
  typedef struct packed {
    logic [1:0] m;
    logic       s;
    logic       p;
    logic       b;
    logic       f;
  } exp_t;

  exp_t exp_q[$];
  logic last_par = 1'b0;

  task automatic model_push(input logic [7:0] d, input logic pe, input logic pt);
    logic par;
    exp_t e;
    par = (^d) ^ pt;
    last_par = par;
    e = '{m: 2'd0, s: d[0], p: par, b: 1'b1, f: 1'b0};
    exp_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e = '{m: 2'd2, s: d[i], p: par, b: 1'b1, f: 1'b0};
      exp_q.push_back(e);
    end
    if (pe) begin
      e = '{m: 2'd3, s: 1'b0, p: par, b: 1'b1, f: 1'b0};
      exp_q.push_back(e);
    end
    e = '{m: 2'd1, s: 1'b0, p: par, b: 1'b1, f: 1'b1};
    exp_q.push_back(e);
  endtask

  // Compare process: checks every cycle at the falling edge, then decides
  // whether the coming rising edge will accept a word.
  always @(negedge CLK) begin
    exp_t e;
    exp_t a;
    bit   idle_now;
    if (!RST) begin
      exp_q.delete();
      last_par = 1'b0;
      e = '{m: 2'd1, s: 1'b0, p: 1'b0, b: 1'b0, f: 1'b0};
      idle_now = 1'b0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      idle_now = 1'b0;
    end else begin
      e = '{m: 2'd1, s: 1'b0, p: last_par, b: 1'b0, f: 1'b0};
      idle_now = 1'b1;
    end
    a = '{m: bus.mux_sel, s: bus.ser_data, p: bus.par_bit,
          b: bus.busy, f: bus.frame_done};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL cycle t=%0t mux=%0d/%0d ser=%b/%b par=%b/%b busy=%b/%b fd=%b/%b (got/want)",
               $time, a.m, e.m, a.s, e.s, a.p, e.p, a.b, e.b, a.f, e.f);
    end
    if (idle_now && bus.DATA_VALID)
      model_push(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
  end

  // ---------------- directed stimulus ----------------
  // Sends one word and traces 12 cycles after the accept edge against
  // hand-computed literals.
  task automatic send(input string nm, input logic [7:0] d, input logic pe,
                      input logic pt, input bit hold, input bit mess,
                      input logic [23:0] exp_seq, input int exp_busy,
                      input int exp_fd, input logic exp_par);
    logic [23:0] seq;
    logic [7:0]  bits;
    int          nb;
    int          fdc;
    logic        p1;
    @(posedge CLK); #1;
    bus.P_DATA = d; bus.PAR_EN = pe; bus.PAR_TYP = pt; bus.DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    if (!hold) bus.DATA_VALID = 1'b0;
    seq = '0; bits = '0; nb = 0; fdc = 0; p1 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      seq = {seq[21:0], bus.mux_sel};
      if (bus.busy) nb++;
      if (bus.frame_done) fdc = c;
      if (bus.mux_sel == 2'd2) bits = {bus.ser_data, bits[7:1]};
      if (c == 1) p1 = bus.par_bit;
      if (mess && c == 3) begin
        bus.P_DATA = ~d; bus.PAR_TYP = ~pt; bus.PAR_EN = ~pe;
      end
    end
    chk({nm, "_seq"},  int'(seq),  int'(exp_seq));
    chk({nm, "_busy"}, nb,         exp_busy);
    chk({nm, "_fd"},   fdc,        exp_fd);
    chk({nm, "_bits"}, int'(bits), int'(d));
    chk({nm, "_par"},  int'(p1),   int'(exp_par));
    bus.DATA_VALID = 1'b0;
    bus.P_DATA = d; bus.PAR_TYP = pt; bus.PAR_EN = pe;
    repeat (14) @(posedge CLK);
  endtask

  initial begin
    RST = 1'b0;
    bus.P_DATA = '0; bus.DATA_VALID = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_mux",  int'(bus.mux_sel),    1);
    chk("rst_busy", int'(bus.busy),       0);
    chk("rst_fd",   int'(bus.frame_done), 0);
    chk("rst_ser",  int'(bus.ser_data),   0);
    chk("rst_par",  int'(bus.par_bit),    0);
    RST = 1'b1;
    repeat (2) @(posedge CLK);

    // 8'hA5 even/odd parity, then no parity, then held request, then
    // mid-frame input changes.
    send("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 24'h2AAAB5, 11, 11, 1'b0);
    send("a5_odd",  8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 24'h2AAAB5, 11, 11, 1'b1);
    send("x01_np",  8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 24'h2AAA95, 10, 10, 1'b1);
    send("x3c_hold",8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 24'h2AAA94, 11, 10, 1'b0);
    send("a5_mess", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 24'h2AAAB5, 11, 11, 1'b0);

    // Reset during data bit 3: outputs return to idle values at once.
    @(posedge CLK); #1;
    bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1; bus.DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.DATA_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    chk("pre_rst_mux", int'(bus.mux_sel), 2);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_mux",  int'(bus.mux_sel),    1);
    chk("mid_rst_busy", int'(bus.busy),       0);
    chk("mid_rst_fd",   int'(bus.frame_done), 0);
    chk("mid_rst_par",  int'(bus.par_bit),    0);
    @(posedge CLK);
    @(posedge CLK); #1;
    RST = 1'b1;
    send("post_rst", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 24'h2AAA95, 10, 10, 1'b1);

    repeat (3) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
